// File: rtl/alarm_pkg.sv
// alarm_pkg
//   Shared definitions for the alarm response controller: FSM state encoding
//   and the default ring timeout / snooze limit constants.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  localparam int RING_SECS_DEF  = 60;
  localparam int MAX_SNOOZE_DEF = 3;

endpackage

// File: rtl/alarm_ring_timer.sv
// ring_timer
//   Seconds counter and beep cadence for one ringing episode.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     clear     : restart the episode (count 0, beep on)
//     run       : controller is currently ringing
//     sec_tick  : 1-cycle once-per-second strobe
//     beep      : beep phase, toggles every second while running
//     done      : this sec_tick completes the final second of the episode
module ring_timer #(
  parameter int RING_SECS = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  input  logic sec_tick,
  output logic beep,
  output logic done
);

  localparam int CW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;

  logic [CW-1:0] ring_cnt;
  logic          last_sec;

  assign last_sec = (ring_cnt == CW'(RING_SECS - 1));
  assign done     = run & sec_tick & last_sec;

  // The counter stops at the last second; the controller leaves RINGING on
  // that tick, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      ring_cnt <= '0;
      beep     <= 1'b0;
    end else if (clear) begin
      ring_cnt <= '0;
      beep     <= 1'b1;
    end else if (run && sec_tick && !last_sec) begin
      ring_cnt <= ring_cnt + CW'(1);
      beep     <= ~beep;
    end
  end

endmodule

// File: rtl/alarm_ringer.sv
// alarm_ringer
//   Alarm response controller fed by the time/alarm datapath.
//   Ports:
//     funct_clk, rst : clock, synchronous active-high reset
//     sec_tick       : 1-cycle once-per-second strobe
//     alarm_on       : alarm armed switch (level)
//     setting        : user adjusting time/alarm; blocks new triggers
//     Z              : time==alarm match (level for the whole minute)
//     z_s            : snooze period elapsed
//     stop_btn       : stop request pulse
//     snooze_btn     : snooze request pulse
//     buzzer         : beep drive
//     led_ring       : ringing indicator
//     led_snooze     : snoozing indicator
//     missed         : sticky, alarm timed out unanswered
//     snooze_left    : snoozes remaining for this alarm event
//     snooze_rst     : holds the external snooze counter cleared
//     snoozeEN       : enables the external snooze counter
module alarm_ringer
  import alarm_pkg::*;
#(
  parameter  int RING_SECS  = RING_SECS_DEF,
  parameter  int MAX_SNOOZE = MAX_SNOOZE_DEF,
  localparam int SNW        = $clog2(MAX_SNOOZE + 1)
) (
  input  logic           funct_clk,
  input  logic           rst,
  input  logic           sec_tick,
  input  logic           alarm_on,
  input  logic           setting,
  input  logic           Z,
  input  logic           z_s,
  input  logic           stop_btn,
  input  logic           snooze_btn,
  output logic           buzzer,
  output logic           led_ring,
  output logic           led_snooze,
  output logic           missed,
  output logic [SNW-1:0] snooze_left,
  output logic           snooze_rst,
  output logic           snoozeEN
);

  state_t state_q, state_d;
  logic   z_q;
  logic   trig;
  logic   start_ring;
  logic   take_snooze;
  logic   timeout;
  logic   beep;
  logic   done;
  logic   abort;

  // z_q resets high so a reset inside a matching minute cannot ring.
  assign trig  = Z & ~z_q & alarm_on & ~setting;
  assign abort = ~alarm_on | stop_btn;

  ring_timer #(
    .RING_SECS(RING_SECS)
  ) u_timer (
    .clk     (funct_clk),
    .rst     (rst),
    .clear   (start_ring),
    .run     (state_q == RINGING),
    .sec_tick(sec_tick),
    .beep    (beep),
    .done    (done)
  );

  // Priority: disarm/stop, then snooze, then snooze-expiry/timeout.
  // A snooze request with no snoozes left falls through to the timeout check.
  always_comb begin
    state_d     = state_q;
    start_ring  = 1'b0;
    take_snooze = 1'b0;
    timeout     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          state_d    = RINGING;
          start_ring = 1'b1;
        end
      end
      RINGING: begin
        if (abort) begin
          state_d = IDLE;
        end else if (snooze_btn && snooze_left != '0) begin
          state_d     = SNOOZE;
          take_snooze = 1'b1;
        end else if (done) begin
          state_d = IDLE;
          timeout = 1'b1;
        end
      end
      SNOOZE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (z_s) begin
          state_d    = RINGING;
          start_ring = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge funct_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      z_q         <= 1'b1;
      missed      <= 1'b0;
      snooze_left <= SNW'(MAX_SNOOZE);
    end else begin
      state_q <= state_d;
      z_q     <= Z;
      if (abort)        missed <= 1'b0;
      else if (timeout) missed <= 1'b1;
      if (state_q == IDLE && trig)
        snooze_left <= SNW'(MAX_SNOOZE);
      else if (take_snooze)
        snooze_left <= snooze_left - SNW'(1);
    end
  end

  // Outputs decode registered state only, so they follow the transition by one cycle.
  assign led_ring   = (state_q == RINGING);
  assign led_snooze = (state_q == SNOOZE);
  assign buzzer     = led_ring & beep;
  assign snoozeEN   = led_snooze;
  assign snooze_rst = ~led_snooze;

endmodule

// File: tb/tb_alarm_ringer.sv
// tb_alarm_ringer
//   Directed bench for alarm_ringer with an every-cycle comparison against a
//   behavioural model plus hand-computed literal checks.
module tb_alarm_ringer;

  localparam int RING_SECS  = 60;
  localparam int MAX_SNOOZE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sec_tick = 1'b0, alarm_on = 1'b0, setting = 1'b0;
  logic       Z = 1'b0, z_s = 1'b0, stop_btn = 1'b0, snooze_btn = 1'b0;
  logic       buzzer, led_ring, led_snooze, missed, snooze_rst, snoozeEN;
  logic [1:0] snooze_left;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  alarm_ringer #(.RING_SECS(RING_SECS), .MAX_SNOOZE(MAX_SNOOZE)) dut (
    .funct_clk  (clk),
    .rst        (rst),
    .sec_tick   (sec_tick),
    .alarm_on   (alarm_on),
    .setting    (setting),
    .Z          (Z),
    .z_s        (z_s),
    .stop_btn   (stop_btn),
    .snooze_btn (snooze_btn),
    .buzzer     (buzzer),
    .led_ring   (led_ring),
    .led_snooze (led_snooze),
    .missed     (missed),
    .snooze_left(snooze_left),
    .snooze_rst (snooze_rst),
    .snoozeEN   (snoozeEN)
  );

  // Behavioural model: mode 0 idle, 1 ringing, 2 snoozing.
  // Buzzer phase is the parity of whole seconds rung so far.
  int m_mode  = 0;
  int m_secs  = 0;
  int m_left  = MAX_SNOOZE;
  bit m_miss  = 1'b0;
  bit m_zprev = 1'b1;

  always @(posedge clk) begin
    bit new_match;
    if (rst) begin
      m_mode = 0; m_secs = 0; m_left = MAX_SNOOZE; m_miss = 1'b0; m_zprev = 1'b1;
    end else begin
      new_match = Z && !m_zprev && alarm_on && !setting;
      m_zprev = Z;
      if (stop_btn || !alarm_on) m_miss = 1'b0;
      case (m_mode)
        0: if (new_match) begin m_mode = 1; m_secs = 0; m_left = MAX_SNOOZE; end
        1: begin
          if (!alarm_on || stop_btn) m_mode = 0;
          else if (snooze_btn && m_left > 0) begin m_mode = 2; m_left = m_left - 1; end
          else if (sec_tick) begin
            if (m_secs == RING_SECS - 1) begin m_mode = 0; m_miss = 1'b1; end
            else m_secs = m_secs + 1;
          end
        end
        default: begin
          if (!alarm_on || stop_btn) m_mode = 0;
          else if (z_s) begin m_mode = 1; m_secs = 0; end
        end
      endcase
    end
  end

  function automatic logic [7:0] model_vec();
    logic ring, snz;
    ring = (m_mode == 1);
    snz  = (m_mode == 2);
    return {ring && (m_secs % 2 == 0), ring, snz, m_miss, !snz, snz, 2'(m_left)};
  endfunction

  always @(negedge clk) begin
    logic [7:0] act, exp_v;
    if (chk_on) begin
      act   = {buzzer, led_ring, led_snooze, missed, snooze_rst, snoozeEN, snooze_left};
      exp_v = model_vec();
      n_vec = n_vec + 1;
      if (act !== exp_v) begin
        n_err = n_err + 1;
        $display("FAIL cycle_model t=%0t got %b want %b (buz,ring,snz,miss,srst,sen,left)",
                 $time, act, exp_v);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_vec = n_vec + 1;
    if (act !== exp_v) begin
      n_err = n_err + 1;
      $display("FAIL %s got %0h want %0h", name, act, exp_v);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sec();
    sec_tick = 1'b1; tick(); sec_tick = 1'b0; tick();
  endtask

  task automatic stop();
    stop_btn = 1'b1; tick(); stop_btn = 1'b0;
  endtask

  task automatic snooze();
    snooze_btn = 1'b1; tick(); snooze_btn = 1'b0;
  endtask

  task automatic wake();
    z_s = 1'b1; tick(); z_s = 1'b0;
  endtask

  initial begin
    // Reset values
    tick(2);
    chk_on = 1'b1;
    check("reset_ring",   8'(led_ring),    8'd0);
    check("reset_srst",   8'(snooze_rst),  8'd1);
    check("reset_left",   8'(snooze_left), 8'd3);
    rst = 1'b0;
    tick();

    // 1: ring on Z rise, buzzer cadence, no re-ring after stop while Z high
    alarm_on = 1'b1; tick();
    Z = 1'b1; tick();
    check("t1_ring",      8'(led_ring), 8'd1);
    check("t1_buz_on",    8'(buzzer),   8'd1);
    sec();
    check("t1_buz_off",   8'(buzzer),   8'd0);
    sec();
    check("t1_buz_on2",   8'(buzzer),   8'd1);
    stop(); tick(3);
    check("t1_no_rering", 8'(led_ring), 8'd0);
    Z = 1'b0; tick();

    // 2/3: snooze three times, fourth is refused, stop returns to idle
    Z = 1'b1; tick();
    snooze();
    check("t2_snz", {4'd0, led_snooze, snoozeEN, snooze_rst, 1'b0}, 8'b0000_1100);
    check("t2_left",      8'(snooze_left), 8'd2);
    tick(2);
    wake();
    check("t2_rering",    {6'd0, led_ring, buzzer}, 8'd3);
    snooze(); wake();
    snooze();
    check("t3_left0",     8'(snooze_left), 8'd0);
    wake(); sec();
    snooze();
    check("t3_refused",   {6'd0, led_ring, led_snooze}, 8'd2);
    stop();
    check("t3_stop_srst", 8'(snooze_rst), 8'd1);
    Z = 1'b0; tick();

    // 4: unanswered ring times out, stop clears missed
    Z = 1'b1; tick();
    repeat (RING_SECS - 1) sec();
    check("t4_still_ring", 8'(led_ring), 8'd1);
    sec();
    check("t4_missed",    {6'd0, missed, led_ring}, 8'd2);
    stop();
    check("t4_miss_clr",  8'(missed), 8'd0);
    Z = 1'b0; tick();

    // Timeout then disarm clears missed; snooze beats a simultaneous timeout
    Z = 1'b1; tick();
    repeat (RING_SECS) sec();
    alarm_on = 1'b0; tick();
    check("t4_disarm_clr", 8'(missed), 8'd0);
    alarm_on = 1'b1; Z = 1'b0; tick();
    Z = 1'b1; tick();
    repeat (RING_SECS - 1) sec();
    sec_tick = 1'b1; snooze_btn = 1'b1; tick();
    sec_tick = 1'b0; snooze_btn = 1'b0;
    check("t4_snz_wins",  {6'd0, led_snooze, missed}, 8'd2);
    stop(); Z = 1'b0; tick();

    // 5: blocked triggers, disarm during snooze
    setting = 1'b1; Z = 1'b1; tick(2);
    check("t5_setting",   8'(led_ring), 8'd0);
    Z = 1'b0; setting = 1'b0; alarm_on = 1'b0; tick();
    Z = 1'b1; tick(2);
    check("t5_disarmed",  8'(led_ring), 8'd0);
    Z = 1'b0; alarm_on = 1'b1; tick();
    Z = 1'b1; tick();
    snooze();
    alarm_on = 1'b0; tick();
    check("t5_snz_abort", {6'd0, led_ring, led_snooze}, 8'd0);
    alarm_on = 1'b1; Z = 1'b0; tick();

    // 6: reset mid-ring with Z high, then stop+snooze together
    Z = 1'b1; tick(); sec();
    rst = 1'b1; tick();
    check("t6_rst", {buzzer, led_ring, led_snooze, missed, snooze_rst, snoozeEN, snooze_left},
          8'b0000_1011);
    rst = 1'b0; tick(3);
    check("t6_no_retrig", 8'(led_ring), 8'd0);
    Z = 1'b0; tick();
    Z = 1'b1; tick();
    stop_btn = 1'b1; snooze_btn = 1'b1; tick();
    stop_btn = 1'b0; snooze_btn = 1'b0;
    check("t6_stop_wins", {6'd0, led_ring, led_snooze}, 8'd0);
    Z = 1'b0; tick(2);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
